// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared processor definitions for the memory port arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   // Requester ids; the value doubles as the rsel encoding.
   typedef enum logic [1:0] {
      ARB_DATA  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_HOST  = 2'd2
   } arb_src_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   // Cycles the host may be refused before it jumps the priority order.
   localparam int ARB_STARVE_LIMIT = 8;
   localparam int ARB_STARVE_W     = $clog2(ARB_STARVE_LIMIT + 1);

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Purpose : counts consecutive cycles the host is kept waiting.
// Latency : starved is registered; reflects history up to the previous cycle.
// Backpressure: none; observes h_req/h_gnt only.
//
// Ports: clock, reset (sync, active-high), h_req, h_gnt in; starved out
// (high once the count has saturated at ARB_STARVE_LIMIT).
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic h_req,
   input  logic h_gnt,
   output logic starved
);

   localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(ARB_STARVE_LIMIT);

   logic [ARB_STARVE_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || !h_req || h_gnt) begin
         count <= '0;
      end else if (count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   assign starved = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates data, fetch and host requesters onto one sync RAM port.
// Latency : grant combinational with req; read data valid one cycle after grant.
// Backpressure: losing requesters hold req until gnt; data may lock the port.
//
// Ports: clock, reset (sync, active-high); d_* data-stage request with lock,
// f_* fetch read request, h_* host request; *_gnt same-cycle grants;
// rvalid/rsel/rdata return path; mem_* single-port RAM interface.
// Build option: MEM_ARB_HOST_EN enables host arbitration and its starvation
// guard; without it the host ports remain but h_gnt is tied low.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
)
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic                 d_lock,
   input  logic [ADDR_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_gnt,
   input  logic                 f_req,
   input  logic [ADDR_SIZE-1:0] f_addr,
   output logic                 f_gnt,
   input  logic                 h_req,
   input  logic                 h_we,
   input  logic [ADDR_SIZE-1:0] h_addr,
   input  logic [WORD_SIZE-1:0] h_wdata,
   output logic                 h_gnt,
   output logic                 rvalid,
   output logic [1:0]           rsel,
   output logic [WORD_SIZE-1:0] rdata,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   arb_state_t state, state_nxt;
   arb_src_t   win_src;
   arb_src_t   rsel_q;
   logic       rvalid_q;
   logic       rd_grant;
   logic       host_starved;

`ifdef MEM_ARB_HOST_EN
   localparam bit HOST_EN = 1'b1;

   arb_starve_counter u_starve (
      .clock   (clock),
      .reset   (reset),
      .h_req   (h_req),
      .h_gnt   (h_gnt),
      .starved (host_starved)
   );
`else
   localparam bit HOST_EN = 1'b0;

   assign host_starved = 1'b0;
`endif

   // Grant selection and lock FSM. Nothing is granted while reset is high.
   always_comb begin
      d_gnt     = 1'b0;
      f_gnt     = 1'b0;
      h_gnt     = 1'b0;
      state_nxt = state;
      if (!reset) begin
         case (state)
            ARB_IDLE: begin
               // A starved host (which is still requesting, since requesters
               // hold until granted) overrides the normal order.
               if (HOST_EN && h_req && host_starved) h_gnt = 1'b1;
               else if (d_req)                       d_gnt = 1'b1;
               else if (f_req)                       f_gnt = 1'b1;
               else if (HOST_EN && h_req)            h_gnt = 1'b1;
            end
            ARB_LOCKED: begin
               // Lock is never broken by starvation; only data proceeds.
               d_gnt = d_req;
            end
            default: ;
         endcase
         if (d_gnt) state_nxt = d_lock ? ARB_LOCKED : ARB_IDLE;
      end
   end

   // RAM port mux from the winner; idle port performs no write.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      win_src   = ARB_DATA;
      if (d_gnt) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         win_src   = ARB_DATA;
      end else if (f_gnt) begin
         mem_addr  = f_addr;
         win_src   = ARB_FETCH;
      end else if (h_gnt) begin
         mem_we    = h_we;
         mem_addr  = h_addr;
         mem_wdata = h_wdata;
         win_src   = ARB_HOST;
      end
   end

   assign rd_grant = (d_gnt | f_gnt | h_gnt) & ~mem_we;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ARB_IDLE;
         rvalid_q <= 1'b0;
         rsel_q   <= ARB_DATA;
      end else begin
         state    <= state_nxt;
         rvalid_q <= rd_grant;
         if (rd_grant) rsel_q <= win_src;
      end
   end

   assign rvalid = rvalid_q;
   assign rsel   = rsel_q;
   assign rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 ADDR_SIZE, 18, address width.
REQ-002 WORD_SIZE, 18, data width.
REQ-003 clock  input  1  single system clock; all state on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_req  input  1  data-stage access request (load/store).
REQ-006 d_we  input  1  data-stage write (1) / read (0).
REQ-007 d_lock  input  1  data-stage holds the port after this grant.
REQ-008 d_addr  input  ADDR_SIZE  data-stage address.
REQ-009 d_wdata  input  WORD_SIZE  data-stage write data.
REQ-010 d_gnt  output  1  data request accepted this cycle.
REQ-011 f_req  input  1  instruction-fetch read request.
REQ-012 f_addr  input  ADDR_SIZE  fetch address (ip).
REQ-013 f_gnt  output  1  fetch request accepted this cycle.
REQ-014 h_req  input  1  host/debug access request.
REQ-015 h_we  input  1  host write (1) / read (0).
REQ-016 h_addr  input  ADDR_SIZE  host address.
REQ-017 h_wdata  input  WORD_SIZE  host write data.
REQ-018 h_gnt  output  1  host request accepted this cycle.
REQ-019 rvalid  output  1  read data valid for a read granted the previous cycle.
REQ-020 rsel  output  2  owner of rvalid data: 0 data, 1 fetch, 2 host.
REQ-021 rdata  output  WORD_SIZE  read data, equals mem_rdata.
REQ-022 mem_addr  output  ADDR_SIZE  address to single-port synchronous RAM.
REQ-023 mem_we  output  1  RAM write enable.
REQ-024 mem_wdata  output  WORD_SIZE  RAM write data.
REQ-025 mem_rdata  input  WORD_SIZE  RAM read data, valid one cycle after address.

Function
REQ-026 At most one gnt SHALL be high per cycle; gnt is combinational and same-cycle with req; mem_addr/mem_we/mem_wdata SHALL be muxed from the winner; with no winner, mem_we=0.
REQ-027 Requesters hold req/addr/we/wdata stable until their gnt; a gnt with req low SHALL never occur.
REQ-028 Priority in ARB_IDLE: host if starve count == ARB_STARVE_LIMIT, else data > fetch > host.
REQ-029 Starve count SHALL increment (saturating at ARB_STARVE_LIMIT) each cycle h_req=1 and h_gnt=0, and clear when h_gnt=1 or h_req=0.
REQ-030 States ARB_IDLE, ARB_LOCKED; IDLE->LOCKED on d_gnt with d_lock=1; LOCKED->IDLE on d_gnt with d_lock=0.
REQ-031 In ARB_LOCKED only data SHALL be granted; f_gnt=h_gnt=0; a saturated starve count SHALL NOT break the lock.
REQ-032 The cycle after a read grant (we=0), rvalid=1, rsel=registered winner id, rdata=mem_rdata; writes produce no rvalid.
REQ-033 Back-to-back reads SHALL sustain one grant and one rvalid per cycle.

Reset
REQ-034 On reset: state ARB_IDLE, starve count 0, rvalid=0, rsel=0; during reset all gnt=0, mem_we=0.
REQ-035 Reset mid-lock or with a read in flight SHALL drop both; rvalid=0 the cycle after reset.

Configuration
REQ-036 MEM_ARB_HOST_EN defined: host port arbitrated with starvation guard as above.
REQ-037 MEM_ARB_HOST_EN undefined: host ports remain, h_gnt tied 0, starve counter absent, rsel never 2.

Structure
REQ-038 Shared processor package SHALL hold arb_src_t (ARB_DATA=0, ARB_FETCH=1, ARB_HOST=2), arb_state_t (ARB_IDLE, ARB_LOCKED), ARB_STARVE_LIMIT=8.
REQ-039 Starve counter SHALL be sub-module arb_starve_counter; priority mux and FSM stay in mem_port_arbiter.

Verification
REQ-040 d_req read 0x00010 and f_req 0x00200 same cycle -> d_gnt=1, f_gnt=0; next cycle rvalid=1, rsel=0, f_gnt=1.
REQ-041 f_req held high, h_req=1 read -> h_gnt=0 for 8 cycles, h_gnt=1 on 9th, starve count then 0.
REQ-042 d_we=1, d_lock=1 at 0x00100 with f_req high -> f_gnt=0 until a d_gnt with d_lock=0; f_gnt=1 the following cycle.
REQ-043 h_we=1, h_addr=0x3FFFF, h_wdata=0x2AAAA alone -> mem_we=1 with those values, rvalid=0 next cycle.
REQ-044 reset in ARB_LOCKED with read in flight -> rvalid=0 next cycle; pending f_req granted first cycle after reset release.
REQ-045 MEM_ARB_HOST_EN undefined, h_req=1 alone for 20 cycles -> h_gnt=0, mem_we=0 throughout.
